// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared constants and types for the writeback port arbiter
package wb_port_arbiter_pkg;

    localparam int ASIZE_DEFAULT      = 5;
    localparam int DSIZE_DEFAULT      = 32;
    localparam int DEPTH_DEFAULT      = 2;
    localparam int STARVE_MAX_DEFAULT = 4;
    localparam int R0_ADDR            = 0;

    // Which source owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_PIPE = 2'd1,
        GRANT_FIFO = 2'd2
    } grant_e;

endpackage

// File: rtl/wb_port_arbiter_sync_fifo.sv
// rtl/wb_port_arbiter_sync_fifo.sv - pending multi-cycle result FIFO with per-entry address visibility
// Ports: push/push_addr/push_data enqueue, pop dequeues the head, full/empty
// from the registered count, head_addr/head_data show the oldest entry,
// ent_valid/ent_addr expose every slot for hazard comparison.
module sync_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int AW    = ASIZE_DEFAULT,
    parameter int DW    = DSIZE_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [AW-1:0]             push_addr,
    input  logic [DW-1:0]             push_data,
    input  logic                      pop,
    output logic                      full,
    output logic                      empty,
    output logic [AW-1:0]             head_addr,
    output logic [DW-1:0]             head_data,
    output logic [DEPTH-1:0]          ent_valid,
    output logic [DEPTH-1:0][AW-1:0]  ent_addr
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [PW:0]               count_q, count_d;
    logic [DEPTH-1:0]          valid_q, valid_d;
    logic [DEPTH-1:0][AW-1:0]  addr_q, addr_d;
    logic [DEPTH-1:0][DW-1:0]  data_q, data_d;
    logic                      push_ok, pop_ok;

    assign full      = (count_q == (PW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign head_addr = addr_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];
    assign ent_valid = valid_q;
    assign ent_addr  = addr_q;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        addr_d   = addr_q;
        data_d   = data_q;
        // Pop clears its slot before push sets one; the two never share a
        // slot because push is blocked when full and pop when empty.
        if (pop_ok) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end
        if (push_ok) begin
            valid_d[wr_ptr_q] = 1'b1;
            addr_d[wr_ptr_q]  = push_addr;
            data_d[wr_ptr_q]  = push_data;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (PW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write-port arbiter between MEM/WB writeback and a multi-cycle unit
// Ports: pipe_* in-order writeback request, mc_* multi-cycle result stream
// with mc_ready backpressure, raddr1/raddr2/id_waddr ID-stage addresses,
// rf_* the shared register-file write port, pipe_stall freezes MEM/WB and
// upstream, rf_hazard tells ID to stall on a pending buffered result.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int ASIZE      = ASIZE_DEFAULT,
    parameter int DSIZE      = DSIZE_DEFAULT,
    parameter int DEPTH      = DEPTH_DEFAULT,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pipe_wen,
    input  logic [ASIZE-1:0] pipe_waddr,
    input  logic [DSIZE-1:0] pipe_wdata,
    input  logic             mc_valid,
    output logic             mc_ready,
    input  logic [ASIZE-1:0] mc_waddr,
    input  logic [DSIZE-1:0] mc_wdata,
    input  logic [ASIZE-1:0] raddr1,
    input  logic [ASIZE-1:0] raddr2,
    input  logic [ASIZE-1:0] id_waddr,
    output logic             rf_wen,
    output logic [ASIZE-1:0] rf_waddr,
    output logic [DSIZE-1:0] rf_wdata,
    output logic             pipe_stall,
    output logic             rf_hazard
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0]               starve_q, starve_d;
    logic                        fifo_full, fifo_empty, fifo_pop, mc_push;
    logic [ASIZE-1:0]            head_addr;
    logic [DSIZE-1:0]            head_data;
    logic [DEPTH-1:0]            ent_valid;
    logic [DEPTH-1:0][ASIZE-1:0] ent_addr;
    logic                        pipe_req, starved, ent_hit;
    grant_e                      grant;

    function automatic logic id_hit(input logic [ASIZE-1:0] a);
        return (a != ASIZE'(R0_ADDR)) && ((a == raddr1) || (a == raddr2) || (a == id_waddr));
    endfunction

    assign pipe_req = pipe_wen && (pipe_waddr != ASIZE'(R0_ADDR));
    assign starved  = (starve_q == SW'(STARVE_MAX));
    // Readiness comes only from the registered count, so a full FIFO
    // refuses a result even in a cycle where it pops.
    assign mc_ready = rst && !fifo_full;
    // r0 results are handshaked but dropped so they never occupy a slot.
    assign mc_push  = mc_valid && mc_ready && (mc_waddr != ASIZE'(R0_ADDR));

    sync_fifo #(
        .AW    (ASIZE),
        .DW    (DSIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (mc_push),
        .push_addr (mc_waddr),
        .push_data (mc_wdata),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_addr (head_addr),
        .head_data (head_data),
        .ent_valid (ent_valid),
        .ent_addr  (ent_addr)
    );

    always_comb begin
        grant = GRANT_NONE;
        if (!rst) begin
            grant = GRANT_NONE;
        end else if (!fifo_empty && (!pipe_req || starved)) begin
            grant = GRANT_FIFO;
        end else if (pipe_req) begin
            grant = GRANT_PIPE;
        end
    end

    always_comb begin
        rf_wen   = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        case (grant)
            GRANT_PIPE: begin
                rf_wen   = 1'b1;
                rf_waddr = pipe_waddr;
                rf_wdata = pipe_wdata;
            end
            GRANT_FIFO: begin
                rf_wen   = 1'b1;
                rf_waddr = head_addr;
                rf_wdata = head_data;
            end
            default: ;
        endcase
    end

    assign fifo_pop   = (grant == GRANT_FIFO);
    // A pop while the pipeline wants the port is a preemption.
    assign pipe_stall = fifo_pop && pipe_req;

    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || fifo_pop) begin
            starve_d = '0;
        end else if ((grant == GRANT_PIPE) && !starved) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    always_comb begin
        ent_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && id_hit(ent_addr[i])) begin
                ent_hit = 1'b1;
            end
        end
    end

    assign rf_hazard = rst && (ent_hit || (mc_push && id_hit(mc_waddr)));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic        clk, rst;
    logic        pipe_wen, mc_valid, mc_ready;
    logic [4:0]  pipe_waddr, mc_waddr, raddr1, raddr2, id_waddr, rf_waddr;
    logic [31:0] pipe_wdata, mc_wdata, rf_wdata;
    logic        rf_wen, pipe_stall, rf_hazard;

    wb_port_arbiter dut (
        .clk(clk), .rst(rst),
        .pipe_wen(pipe_wen), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_waddr(mc_waddr), .mc_wdata(mc_wdata),
        .raddr1(raddr1), .raddr2(raddr2), .id_waddr(id_waddr),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pipe_stall(pipe_stall), .rf_hazard(rf_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
    ent_t mq[$];
    int   starve = 0;

    logic        exp_wen, exp_stall, exp_hazard, exp_ready, exp_pop, exp_push;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;

    function automatic logic hit(input logic [4:0] a);
        return (a != 5'd0) && (a == raddr1 || a == raddr2 || a == id_waddr);
    endfunction

    function automatic logic [40:0] obs_vec();
        return {rf_wen, rf_waddr, rf_wdata, pipe_stall, rf_hazard, mc_ready};
    endfunction

    function automatic logic [40:0] exp_vec();
        return {exp_wen, exp_addr, exp_data, exp_stall, exp_hazard, exp_ready};
    endfunction

    task automatic model_eval();
        logic preq;
        exp_wen = 0; exp_addr = 0; exp_data = 0; exp_stall = 0;
        exp_hazard = 0; exp_ready = 0; exp_pop = 0; exp_push = 0;
        if (rst) begin
            preq      = pipe_wen && pipe_waddr != 5'd0;
            exp_ready = mq.size() < DEPTH;
            exp_push  = mc_valid && exp_ready && mc_waddr != 5'd0;
            if (mq.size() != 0 && (!preq || starve >= SMAX)) begin
                exp_pop = 1; exp_wen = 1; exp_addr = mq[0].a; exp_data = mq[0].d;
                exp_stall = preq;
            end else if (preq) begin
                exp_wen = 1; exp_addr = pipe_waddr; exp_data = pipe_wdata;
            end
            foreach (mq[i]) if (hit(mq[i].a)) exp_hazard = 1;
            if (exp_push && hit(mc_waddr)) exp_hazard = 1;
        end
    endtask

    task automatic model_commit();
        if (!rst) begin
            mq.delete();
            starve = 0;
        end else begin
            if (mq.size() == 0 || exp_pop) starve = 0;
            else if (starve < SMAX) starve++;
            if (exp_pop) mq.delete(0);
            if (exp_push) mq.push_back('{mc_waddr, mc_wdata});
        end
    endtask

    task automatic set_in(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                          input logic mv, input logic [4:0] ma, input logic [31:0] md,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] iw);
        pipe_wen = pw; pipe_waddr = pa; pipe_wdata = pd;
        mc_valid = mv; mc_waddr = ma; mc_wdata = md;
        raddr1 = r1; raddr2 = r2; id_waddr = iw;
    endtask

    task automatic edge_commit();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 1, 5'd4, 32'h4, 0, 0, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec() !== 41'h0) begin
                n_fail++; $display("FAIL reset_outputs cyc %0d: got %h want 0", c, obs_vec());
            end
            edge_commit();
        end
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        model_eval();
        n_checks++;
        if (mc_ready !== 1'b1 || rf_wen !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_release: got %h want %h", obs_vec(), exp_vec());
        end
        edge_commit();
    endtask

    task automatic test_starvation();
        int k = 0;
        for (int c = 0; c < 12 && k < 9; c++) begin
            set_in(1, 5'(k + 1), 32'h100 + 32'(k), c == 0, 5'd20, 32'hDEAD, 0, 0, 0);
            @(negedge clk);
            model_eval();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL starve cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c == 5) begin
                n_checks++;
                if ({rf_wen, rf_waddr, rf_wdata, pipe_stall} !== {1'b1, 5'd20, 32'hDEAD, 1'b1}) begin
                    n_fail++; $display("FAIL starve_preempt: got %b %0d %h %b want 1 20 dead 1",
                                       rf_wen, rf_waddr, rf_wdata, pipe_stall);
                end
            end
            if (c == 6) begin
                n_checks++;
                if ({rf_wen, rf_waddr, pipe_stall} !== {1'b1, 5'd6, 1'b0}) begin
                    n_fail++; $display("FAIL starve_replay: got %b %0d %b want 1 6 0",
                                       rf_wen, rf_waddr, pipe_stall);
                end
            end
            if (!exp_stall) k++;
            edge_commit();
        end
    endtask

    task automatic test_fifo_order();
        for (int c = 0; c < 5; c++) begin
            set_in(c < 2, 5'(c + 1), 32'h50, c < 2, 5'd3, 32'(c + 1), 0, 0, 0);
            @(negedge clk);
            model_eval();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL order cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c >= 2) begin
                n_checks++;
                if ({rf_wen, rf_waddr, rf_wdata} !== ((c == 4) ? 38'h0 : {1'b1, 5'd3, 32'(c - 1)})) begin
                    n_fail++; $display("FAIL order_retire cyc %0d: got %b %0d %h", c, rf_wen, rf_waddr, rf_wdata);
                end
            end
            edge_commit();
        end
    endtask

    task automatic test_backpressure();
        logic [4:0] ma [5] = '{5'd10, 5'd11, 5'd12, 5'd12, 5'd0};
        for (int c = 0; c < 5; c++) begin
            set_in(c < 2, 5'(c + 1), 32'h60, c < 4, ma[c], 32'hA0 + 32'(ma[c]), 0, 0, 0);
            @(negedge clk);
            model_eval();
            n_checks++;
            if (obs_vec() !== exp_vec() || mq.size() > DEPTH) begin
                n_fail++; $display("FAIL backpressure cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c == 2 || c == 3) begin
                n_checks++;
                if ({mc_ready, rf_waddr} !== {c == 3, 5'(c + 8)}) begin
                    n_fail++; $display("FAIL full_no_passthru cyc %0d: got ready %b addr %0d", c, mc_ready, rf_waddr);
                end
            end
            edge_commit();
        end
    endtask

    task automatic test_hazard();
        logic [4:0] r1 [6] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [4:0] r2 [6] = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0};
        logic [4:0] iw [6] = '{5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd0};
        logic       hz [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int c = 0; c < 6; c++) begin
            set_in(c < 4, 5'(c + 1), 32'h70, c == 0 || c == 3, (c == 0) ? 5'd7 : 5'd0, 32'h77,
                   r1[c], r2[c], iw[c]);
            @(negedge clk);
            model_eval();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL hazard cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            n_checks++;
            if (rf_hazard !== hz[c] || (c == 5 && rf_wen !== 1'b0)) begin
                n_fail++; $display("FAIL hazard_flag cyc %0d: got %b want %b (wen %b)", c, rf_hazard, hz[c], rf_wen);
            end
            edge_commit();
        end
    endtask

    task automatic test_r0_pipe();
        for (int c = 0; c < 3; c++) begin
            set_in(c < 2, (c == 0) ? 5'd1 : 5'd0, 32'h80, c == 0, 5'd9, 32'h99, 0, 0, 0);
            @(negedge clk);
            model_eval();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL r0_pipe cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c == 1) begin
                n_checks++;
                if ({rf_wen, rf_waddr, rf_wdata, pipe_stall} !== {1'b1, 5'd9, 32'h99, 1'b0}) begin
                    n_fail++; $display("FAIL r0_grant: got %b %0d %h %b want 1 9 99 0",
                                       rf_wen, rf_waddr, rf_wdata, pipe_stall);
                end
            end
            edge_commit();
        end
    endtask

    task automatic test_reset_midstream();
        for (int c = 0; c < 7; c++) begin
            set_in(c < 2, 5'(c + 1), 32'h90, c < 2, 5'(13 + c), 32'hB0 + 32'(c), 0, 0, 0);
            rst = !(c == 2 || c == 3);
            @(negedge clk);
            model_eval();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL reset_mid cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c >= 2) begin
                n_checks++;
                if ({mc_ready, rf_wen} !== {c >= 4, 1'b0}) begin
                    n_fail++; $display("FAIL reset_discard cyc %0d: got ready %b wen %b", c, mc_ready, rf_wen);
                end
            end
            edge_commit();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) != 0);
            set_in($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom,
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            @(negedge clk);
            model_eval();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            edge_commit();
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_starvation();
        test_fifo_order();
        test_backpressure();
        test_hazard();
        test_r0_pipe();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
